frame_buffer_ctrl: RTL

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

---
 rtl/frame_buffer_ctrl_if.sv | 28 ++
 rtl/frame_buffer_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl_if.sv
// Signal bundle between a pixel/clear requester, the VGA scan logic and frame_buffer_ctrl.
// The master side drives scan position and requests; the slave side (the controller) drives the frame-buffer bus.
interface frame_buffer_ctrl_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        clear_req;
  logic [3:0]  clear_color;
  logic        draw_req;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [3:0]  draw_color;
  logic        draw_ack;
  logic        busy;
  logic        fb_we;
  logic [18:0] fb_write_address;
  logic [3:0]  fb_data_in;
  logic [18:0] fb_read_address;

  modport master (
    output DrawX, DrawY, clear_req, clear_color, draw_req, draw_x, draw_y, draw_color,
    input  draw_ack, busy, fb_we, fb_write_address, fb_data_in, fb_read_address
  );

  modport slave (
    input  DrawX, DrawY, clear_req, clear_color, draw_req, draw_x, draw_y, draw_color,
    output draw_ack, busy, fb_we, fb_write_address, fb_data_in, fb_read_address
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// Frame-buffer write arbiter (single pixel draws, optional full-buffer clear) plus registered scan read address.
// The clear engine is built only when macro FB_CLEAR_EN is defined; otherwise busy is tied low and clear_req is ignored.
module frame_buffer_ctrl #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic              Clk,
  input  logic              Reset,
  frame_buffer_ctrl_if.slave bus
);

  localparam logic [18:0] H_RES_W = 19'(H_RES);

`ifdef FB_CLEAR_EN
  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);
  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAW} state_t;
`endif

  state_t state;
  state_t next_state;

  logic        ack_n;
  logic        we_n;
  logic [18:0] waddr_n;
  logic [3:0]  data_n;

`ifdef FB_CLEAR_EN
  logic [18:0] clear_cnt;
  logic [18:0] cnt_n;
  logic [3:0]  clear_color_q;
  logic [3:0]  color_n;
  logic        busy_n;
`endif

  // The 640-wide case maps to two shifts and an add so no multiplier is built.
  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] xe;
    logic [18:0] ye;
    xe = {9'd0, x};
    ye = {9'd0, y};
    if (H_RES == 640)
      pix_addr = (ye << 9) + (ye << 7) + xe;
    else
      pix_addr = ye * H_RES_W + xe;
  endfunction

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    in_range = (32'(x) < H_RES) && (32'(y) < V_RES);
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset)
      bus.fb_read_address <= '0;
    else if (in_range(bus.DrawX, bus.DrawY))
      bus.fb_read_address <= pix_addr(bus.DrawX, bus.DrawY);
    else
      bus.fb_read_address <= '0;
  end

  // Next-state logic also computes the next value of every registered output,
  // so a write is visible on the bus in the cycle the FSM spends in DRAW/CLEAR.
  always_comb begin
    next_state = state;
    ack_n      = 1'b0;
    we_n       = 1'b0;
    waddr_n    = bus.fb_write_address;
    data_n     = bus.fb_data_in;
`ifdef FB_CLEAR_EN
    cnt_n      = clear_cnt;
    color_n    = clear_color_q;
    busy_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef FB_CLEAR_EN
        if (bus.clear_req) begin
          next_state = CLEAR;
          cnt_n      = '0;
          color_n    = bus.clear_color;
          busy_n     = 1'b1;
          we_n       = 1'b1;
          waddr_n    = '0;
          data_n     = bus.clear_color;
        end else
`endif
        if (bus.draw_req) begin
          next_state = DRAW;
          ack_n      = 1'b1;
          we_n       = in_range(bus.draw_x, bus.draw_y);
          waddr_n    = pix_addr(bus.draw_x, bus.draw_y);
          data_n     = bus.draw_color;
        end
      end
      DRAW: next_state = IDLE;
`ifdef FB_CLEAR_EN
      CLEAR: begin
        if (clear_cnt == LAST_ADDR) begin
          next_state = IDLE;
        end else begin
          cnt_n   = clear_cnt + 19'd1;
          busy_n  = 1'b1;
          we_n    = 1'b1;
          waddr_n = clear_cnt + 19'd1;
          data_n  = clear_color_q;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state                <= IDLE;
      bus.draw_ack         <= 1'b0;
      bus.fb_we            <= 1'b0;
      bus.fb_write_address <= '0;
      bus.fb_data_in       <= '0;
`ifdef FB_CLEAR_EN
      clear_cnt            <= '0;
      clear_color_q        <= '0;
      bus.busy             <= 1'b0;
`endif
    end else begin
      state                <= next_state;
      bus.draw_ack         <= ack_n;
      bus.fb_we            <= we_n;
      bus.fb_write_address <= waddr_n;
      bus.fb_data_in       <= data_n;
`ifdef FB_CLEAR_EN
      clear_cnt            <= cnt_n;
      clear_color_q        <= color_n;
      bus.busy             <= busy_n;
`endif
    end
  end

`ifndef FB_CLEAR_EN
  assign bus.busy = 1'b0;
`endif

endmodule
